// File: rtl/serial_operand_feeder.sv
// rtl/serial_operand_feeder.sv - accepts operand pairs and shifts them out LSB-first for the bit-serial adder
module serial_operand_feeder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             sum_clr,
    output logic             a,
    output logic             b,
    output logic             bit_valid,
    output logic             last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg_a;
    logic [WIDTH-1:0] shreg_b;
    logic [CNT_W-1:0] cnt;
    logic             at_last;
    logic             accept;

    assign at_last = (state == SHIFT) && (cnt == CNT_LAST);
    assign accept  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A new pair may be taken while the MSB is on the wire, giving back-to-back words.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CLEAR;
            CLEAR:   state_nxt = SHIFT;
            SHIFT:   if (at_last) state_nxt = accept ? CLEAR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_a <= '0;
            shreg_b <= '0;
            cnt     <= '0;
        end else if (accept) begin
            shreg_a <= op_a;
            shreg_b <= op_b;
            cnt     <= '0;
        end else if (state == SHIFT) begin
            shreg_a <= {1'b0, shreg_a[WIDTH-1:1]};
            shreg_b <= {1'b0, shreg_b[WIDTH-1:1]};
            cnt     <= at_last ? '0 : cnt + CNT_ONE;
        end
    end

    // Serial outputs come from flops only; in_ready is additionally masked by reset.
    always_comb begin
        in_ready  = rst_n && ((state == IDLE) || at_last);
        sum_clr   = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        bit_valid = 1'b0;
        last      = 1'b0;
        case (state)
            CLEAR: sum_clr = 1'b1;
            SHIFT: begin
                a         = shreg_a[0];
                b         = shreg_b[0];
                bit_valid = 1'b1;
                last      = at_last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// tb/tb_serial_operand_feeder.sv - self-checking bench for serial_operand_feeder
module tb_serial_operand_feeder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         sum_clr, a, b, bit_valid, last;

    serial_operand_feeder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .sum_clr(sum_clr), .a(a), .b(b),
        .bit_valid(bit_valid), .last(last)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int printed = 0;
    int cyc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (printed < 40) begin
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
                printed++;
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Timeline model: a word accepted at the end of cycle T owns cycles T+1 .. T+1+W.
    bit           m_active = 0;
    int           m_start = 0;
    logic [W-1:0] m_a, m_b;
    bit           add_carry = 0;
    logic [W-1:0] add_sum = '0;
    logic [W-1:0] got_sums[$];
    logic [W-1:0] got_a[$];
    logic [W-1:0] got_b[$];
    logic [W-1:0] ser_a = '0, ser_b = '0;
    int           acc_cycles[$];
    int           clr_cycles[$];
    int           last_cycles[$];

    always @(negedge clk) begin
        bit e_clr, e_a, e_b, e_v, e_last, e_rdy;
        int k;
        e_clr = 0; e_a = 0; e_b = 0; e_v = 0; e_last = 0; e_rdy = 0;
        if (!rst_n) begin
            m_active = 0;
        end else begin
            e_rdy = !m_active || (cyc == m_start + W);
            if (m_active && cyc == m_start) e_clr = 1;
            if (m_active && cyc > m_start && cyc <= m_start + W) begin
                k = cyc - m_start - 1;
                e_a = m_a[k];
                e_b = m_b[k];
                e_v = 1;
                e_last = (k == W - 1);
            end
        end
        chk("in_ready", in_ready, e_rdy);
        chk("sum_clr", sum_clr, e_clr);
        chk("a", a, e_a);
        chk("b", b, e_b);
        chk("bit_valid", bit_valid, e_v);
        chk("last", last, e_last);

        // Downstream serial adder, fed from the DUT pins.
        if (sum_clr) begin
            add_carry = 0;
            clr_cycles.push_back(cyc);
        end
        if (bit_valid) begin
            add_sum = {a ^ b ^ add_carry, add_sum[W-1:1]};
            ser_a = {a, ser_a[W-1:1]};
            ser_b = {b, ser_b[W-1:1]};
            add_carry = (a & b) | (add_carry & (a ^ b));
        end
        if (rst_n && e_last) begin
            chk("word_sum", add_sum, W'(m_a + m_b));
            got_sums.push_back(add_sum);
            got_a.push_back(ser_a);
            got_b.push_back(ser_b);
            last_cycles.push_back(cyc);
        end

        if (rst_n && in_valid && e_rdy) begin
            m_active = 1;
            m_start = cyc + 1;
            m_a = op_a;
            m_b = op_b;
            acc_cycles.push_back(cyc);
        end else if (m_active && cyc >= m_start + W) begin
            m_active = 0;
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        in_valid = 1'b1;
        op_a = x;
        op_b = y;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("handshake_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        // Reset state
        #2;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_outs", {sum_clr, a, b, bit_valid, last}, 0);
        idle_cycles(3);
        #1;
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1);
        idle_cycles(2);

        // 1: 05 + 03, latency pins
        send(8'h05, 8'h03);
        idle_cycles(W + 2);
        chk("t1_sum", got_sums[0], 8'h08);
        chk("t1_a_bits", got_a[0], 8'h05);
        chk("t1_b_bits", got_b[0], 8'h03);
        chk("t1_clr_latency", clr_cycles[0] - acc_cycles[0], 1);
        chk("t1_last_latency", last_cycles[0] - acc_cycles[0], 9);

        // 2: FF + 01 leaves a carry that the next sum_clr must clear
        send(8'hFF, 8'h01);
        idle_cycles(W + 2);
        chk("t2_sum", got_sums[1], 8'h00);
        chk("t2_carry_left", add_carry, 1);

        // 3: back-to-back
        send(8'h0A, 8'h14);
        send(8'h33, 8'h11);
        idle_cycles(W + 2);
        chk("t3_sum0", got_sums[2], 8'h1E);
        chk("t3_sum1", got_sums[3], 8'h44);
        chk("t3_gap", acc_cycles[3] - acc_cycles[2], W + 1);
        chk("t3_clr_next", clr_cycles[3] - last_cycles[2], 1);

        // 4: operand churn while busy
        send(8'h5A, 8'hC3);
        in_valid = 1'b1;
        op_a = 8'h11;
        op_b = 8'h22;
        idle_cycles(3);
        op_a = 8'hEE;
        op_b = 8'hDD;
        idle_cycles(2);
        send(8'h77, 8'h88);
        idle_cycles(W + 2);
        chk("t4_inflight_a", got_a[4], 8'h5A);
        chk("t4_inflight_sum", got_sums[4], 8'h1D);
        chk("t4_next_sum", got_sums[5], 8'hFF);
        chk("t4_gap", acc_cycles[5] - acc_cycles[4], W + 1);

        // 5: async reset at bit 3
        send(8'h96, 8'h5A);
        idle_cycles(4);
        chk("t5_pre_bit3", bit_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_abort_outs", {sum_clr, a, b, bit_valid, last}, 0);
        chk("t5_abort_ready", in_ready, 0);
        idle_cycles(2);
        #1;
        rst_n = 1'b1;
        #1;
        chk("t5_release_ready", in_ready, 1);
        send(8'h96, 8'h5A);
        idle_cycles(W + 2);
        chk("t5_sum", got_sums[got_sums.size() - 1], 8'hF0);

        // 6: random words with random gaps
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            send(ra, rb);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(0, 12));
        end
        idle_cycles(W + 3);
        chk("t6_word_count", got_sums.size(), 1007);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
